instr_feeder: RTL and testbench

Instruction-issue block that drives the 32-bit instruction input `in` of `cpu` from a small loadable program buffer. Software or a bench loads words, pulses `start`, and the block presents one instruction per clock with a matching byte PC. It supports stall hold and end-of-program signalling. When idle or finished it presents a NOP so the core executes nothing.

---
 rtl/instr_feeder_if.sv | 26 ++
 rtl/instr_feeder.sv | 133 +++++++++++++
 tb/tb_instr_feeder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/instr_feeder_if.sv
// Load/control and issue bundle between a program loader and instr_feeder.
// The master modport loads and controls; the slave modport is the feeder itself.
interface instr_feeder_if #(
    parameter int AW = 4
);
    logic          load_en;
    logic [31:0]   load_data;
    logic          start;
    logic          stall;
    logic          clear;
    logic [31:0]   instr;
    logic          instr_valid;
    logic [31:0]   pc;
    logic          done;
    logic [AW:0]   count;

    modport master (
        output load_en, load_data, start, stall, clear,
        input  instr, instr_valid, pc, done, count
    );

    modport slave (
        input  load_en, load_data, start, stall, clear,
        output instr, instr_valid, pc, done, count
    );
endinterface

// File: rtl/instr_feeder.sv
// Loadable program buffer that issues one 32-bit instruction per clock to a core,
// with stall hold, end-of-program flag, and a NOP whenever nothing valid is issued.
module instr_feeder #(
    parameter int          DEPTH = 16,
    parameter int          AW    = 4,
    parameter logic [31:0] NOP   = 32'h0000_0013
) (
    input logic          clk,
    input logic          rst,
    instr_feeder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    localparam logic [AW:0] FULL   = (AW + 1)'(DEPTH);
    localparam logic [AW:0] ONE_CT = (AW + 1)'(1);

    logic [31:0] mem_q [DEPTH];

    state_e        state_q, state_d;
    logic [AW:0]   count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [31:0]   instr_q, instr_d;
    logic          instr_valid_q, instr_valid_d;
    logic [31:0]   pc_q, pc_d;
    logic          done_q, done_d;
    logic          mem_we;
    logic [AW-1:0] rd_inc;

    assign rd_inc = rd_ptr_q + AW'(1);

    always_comb begin
        state_d       = state_q;
        count_d       = count_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        instr_d       = instr_q;
        instr_valid_d = instr_valid_q;
        pc_d          = pc_q;
        done_d        = done_q;
        mem_we        = 1'b0;

        if (bus.clear) begin
            state_d       = IDLE;
            count_d       = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            instr_d       = NOP;
            instr_valid_d = 1'b0;
            pc_d          = '0;
            done_d        = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    // start outranks a simultaneous load, so the dropped word never lands.
                    if (bus.start && count_q != '0) begin
                        state_d       = RUN;
                        rd_ptr_d      = '0;
                        instr_d       = mem_q[0];
                        instr_valid_d = 1'b1;
                        pc_d          = '0;
                    end else if (bus.load_en && count_q != FULL) begin
                        mem_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + AW'(1);
                        count_d  = count_q + ONE_CT;
                    end
                end
                RUN: begin
                    if (!bus.stall) begin
                        if (({1'b0, rd_ptr_q} + ONE_CT) < count_q) begin
                            rd_ptr_d = rd_inc;
                            instr_d  = mem_q[rd_inc];
                            pc_d     = 32'({rd_inc, 2'b00});
                        end else begin
                            // pc keeps the last issued address while finished.
                            state_d       = DONE;
                            instr_d       = NOP;
                            instr_valid_d = 1'b0;
                            done_d        = 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.start) begin
                        state_d       = RUN;
                        rd_ptr_d      = '0;
                        instr_d       = mem_q[0];
                        instr_valid_d = 1'b1;
                        pc_d          = '0;
                        done_d        = 1'b0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            count_q       <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            instr_q       <= NOP;
            instr_valid_q <= 1'b0;
            pc_q          <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            pc_q          <= pc_d;
            done_q        <= done_d;
        end
    end

    // NOTE: the buffer has no reset; count gates every read, so stale words are never issued.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_ptr_q] <= bus.load_data;
        end
    end

    assign bus.instr       = instr_q;
    assign bus.instr_valid = instr_valid_q;
    assign bus.pc          = pc_q;
    assign bus.done        = done_q;
    assign bus.count       = count_q;
endmodule

// File: tb/tb_instr_feeder.sv
// Directed bench for instr_feeder: drives and samples 1 ns after each rising edge.
module tb_instr_feeder;
    localparam int          DEPTH = 16;
    localparam int          AW    = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    instr_feeder_if #(.AW(AW)) bus ();

    instr_feeder #(.DEPTH(DEPTH), .AW(AW), .NOP(NOP)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    logic [31:0] prog [3];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] w);
        bus.load_en   = 1'b1;
        bus.load_data = w;
        tick();
        bus.load_en   = 1'b0;
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    task automatic chk_issue(input string name, input logic [31:0] w, input logic [31:0] p);
        n_cmp++;
        if (bus.instr !== w || bus.pc !== p || bus.instr_valid !== 1'b1 || bus.done !== 1'b0) begin
            n_bad++;
            $display("FAIL %s: got instr=%h pc=%0d v=%b d=%b want instr=%h pc=%0d v=1 d=0",
                     name, bus.instr, bus.pc, bus.instr_valid, bus.done, w, p);
        end
    endtask

    task automatic chk_done(input string name, input logic [31:0] p);
        n_cmp++;
        if (bus.instr !== NOP || bus.pc !== p || bus.instr_valid !== 1'b0 || bus.done !== 1'b1) begin
            n_bad++;
            $display("FAIL %s: got instr=%h pc=%0d v=%b d=%b want instr=%h pc=%0d v=0 d=1",
                     name, bus.instr, bus.pc, bus.instr_valid, bus.done, NOP, p);
        end
    endtask

    task automatic chk_idle(input string name, input logic [AW:0] c);
        n_cmp++;
        if (bus.instr !== NOP || bus.pc !== 32'd0 || bus.instr_valid !== 1'b0 ||
            bus.done !== 1'b0 || bus.count !== c) begin
            n_bad++;
            $display("FAIL %s: got instr=%h pc=%0d v=%b d=%b cnt=%0d want instr=%h pc=0 v=0 d=0 cnt=%0d",
                     name, bus.instr, bus.pc, bus.instr_valid, bus.done, bus.count, NOP, c);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 3; i++) load_word(prog[i]);
    endtask

    task automatic test_reset();
        tick();
        chk_idle("reset_powerup", 0);
        rst = 1'b0;
        tick();
        load_prog();
        pulse_start();
        tick();
        chk_issue("reset_prerun", prog[1], 4);
        #2 rst = 1'b1;
        #1 chk_idle("reset_async", 0);
        #1 rst = 1'b0;
        tick();
        chk_idle("reset_after", 0);
    endtask

    task automatic test_start_empty();
        pulse_start();
        chk_idle("start_empty", 0);
        tick();
        chk_idle("start_empty_hold", 0);
    endtask

    task automatic test_basic();
        load_prog();
        n_cmp++;
        if (bus.count !== 5'd3) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 3", bus.count);
        end
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk_issue($sformatf("basic_w%0d", i), prog[i], 32'(i * 4));
            tick();
        end
        chk_done("basic_done", 8);
        tick();
        chk_done("basic_done_hold", 8);
    endtask

    task automatic test_restart();
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            chk_issue($sformatf("restart_w%0d", i), prog[i], 32'(i * 4));
            tick();
        end
        chk_done("restart_done", 8);
    endtask

    task automatic test_stall();
        do_clear();
        load_prog();
        pulse_start();
        chk_issue("stall_w0", prog[0], 0);
        tick();
        chk_issue("stall_w1_a", prog[1], 4);
        bus.stall = 1'b1;
        tick();
        chk_issue("stall_w1_b", prog[1], 4);
        tick();
        chk_issue("stall_w1_c", prog[1], 4);
        bus.stall = 1'b0;
        tick();
        chk_issue("stall_w2", prog[2], 8);
        tick();
        chk_done("stall_done", 8);
    endtask

    task automatic test_clear_run();
        do_clear();
        load_prog();
        pulse_start();
        tick();
        chk_issue("clear_prerun", prog[1], 4);
        bus.stall = 1'b1;
        do_clear();
        bus.stall = 1'b0;
        chk_idle("clear_run", 0);
    endtask

    task automatic test_full();
        for (int i = 1; i <= 17; i++) load_word(32'(i));
        n_cmp++;
        if (bus.count !== 5'd16) begin
            n_bad++;
            $display("FAIL full_count: got %0d want 16", bus.count);
        end
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            chk_issue($sformatf("full_w%0d", i), 32'(i + 1), 32'(i * 4));
            tick();
        end
        chk_done("full_done", 60);
    endtask

    task automatic test_start_load();
        do_clear();
        load_word(32'hAAAA_0001);
        bus.start     = 1'b1;
        bus.load_en   = 1'b1;
        bus.load_data = 32'hBBBB_0002;
        tick();
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
        chk_issue("startload_w0", 32'hAAAA_0001, 0);
        tick();
        chk_done("startload_done", 0);
        n_cmp++;
        if (bus.count !== 5'd1) begin
            n_bad++;
            $display("FAIL startload_count: got %0d want 1", bus.count);
        end
    endtask

    initial begin
        prog[0] = 32'h0020_81B3;
        prog[1] = 32'h0632_0813;
        prog[2] = 32'h0108_03B3;
        bus.load_en   = 1'b0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.stall     = 1'b0;
        bus.clear     = 1'b0;

        test_reset();
        test_start_empty();
        test_basic();
        test_restart();
        test_stall();
        test_clear_run();
        test_full();
        test_start_load();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
